// File: rtl/imm_gen_pipe.sv
// Pipelined RISC-V immediate generator (I/S/B/J/U/SHAMT) with a 2-entry
// output FIFO behind valid/ready, a sideband tag and a sticky illegal-select flag.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [2:0]       imm_src,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  imm_out,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err,
    output logic             err_seen
);

    localparam int EW = XLEN + TAG_W + 1;

    logic [31:0]     w_imm32;
    logic            w_illegal;
    logic [XLEN-1:0] w_imm;
    logic [EW-1:0]   w_new;
    logic            w_push;
    logic            w_pop;
    logic [1:0]      w_count_nx;
    logic [EW-1:0]   w_ent0_nx;
    logic [EW-1:0]   w_ent1_nx;
    logic            w_unused_opcode;

    logic [1:0]      r_count;
    logic [EW-1:0]   r_ent0;
    logic [EW-1:0]   r_ent1;
    logic            r_err_seen;

    // Format decode into a 32-bit value whose bit 31 is the correct sign for every format
    always_comb begin
        w_illegal = 1'b0;
        case (imm_src)
            3'b000:  w_imm32 = {{20{instr[31]}}, instr[31:20]};
            3'b001:  w_imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            3'b010:  w_imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            3'b011:  w_imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            3'b100:  w_imm32 = {instr[31:12], 12'b0};
            3'b101: begin
                if (XLEN == 64) begin
                    w_imm32 = {26'b0, instr[25:20]};
                end else begin
                    w_imm32 = {27'b0, instr[24:20]};
                end
            end
            default: begin
                w_imm32   = 32'b0;
                w_illegal = 1'b1;
            end
        endcase
    end

    // SHAMT and illegal values have bit 31 clear, so sign-extending is safe for all formats
    assign w_imm           = XLEN'($signed(w_imm32));
    assign w_new           = {w_imm, in_tag, w_illegal};
    assign w_unused_opcode = ^instr[6:0];

    assign w_push = in_valid & in_ready;
    assign w_pop  = out_valid & out_ready;

    // FIFO next state; entry 0 is always the head
    always_comb begin
        w_count_nx = r_count;
        w_ent0_nx  = r_ent0;
        w_ent1_nx  = r_ent1;
        case ({w_push, w_pop})
            2'b10: begin
                if (r_count == 2'd0) begin
                    w_ent0_nx  = w_new;
                    w_count_nx = 2'd1;
                end else begin
                    w_ent1_nx  = w_new;
                    w_count_nx = 2'd2;
                end
            end
            2'b01: begin
                w_ent0_nx  = r_ent1;
                w_ent1_nx  = {EW{1'b0}};
                w_count_nx = r_count - 2'd1;
            end
            // push with pop only happens at count 1: new entry replaces the head
            2'b11: begin
                w_ent0_nx  = w_new;
                w_count_nx = 2'd1;
            end
            default: begin
                w_count_nx = r_count;
            end
        endcase
    end

    // State registers: reset beats flush beats push/pop
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count    <= 2'd0;
            r_ent0     <= {EW{1'b0}};
            r_ent1     <= {EW{1'b0}};
            r_err_seen <= 1'b0;
        end else if (flush) begin
            r_count    <= 2'd0;
            r_ent0     <= {EW{1'b0}};
            r_ent1     <= {EW{1'b0}};
        end else begin
            r_count    <= w_count_nx;
            r_ent0     <= w_ent0_nx;
            r_ent1     <= w_ent1_nx;
            r_err_seen <= r_err_seen | (w_push & w_illegal);
        end
    end

    assign in_ready  = (r_count != 2'd2);
    assign out_valid = (r_count != 2'd0);
    assign imm_out   = r_ent0[EW-1 -: XLEN];
    assign out_tag   = r_ent0[TAG_W:1];
    assign out_err   = r_ent0[0];
    assign err_seen  = r_err_seen;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share stimulus.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [31:0] instr, in_tag;
    logic [2:0]  imm_src;

    logic        rdy32, vld32, err32, seen32;
    logic [31:0] imm32, tag32;
    logic        rdy64, vld64, err64, seen64;
    logic [63:0] imm64;
    logic [31:0] tag64;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] e32;
        logic [63:0] e64;
        logic [31:0] tag;
        logic        err;
    } exp_t;

    exp_t q[$];
    logic m_err_seen = 1'b0;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .TAG_W(32)) dut32 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy32),
        .instr(instr), .imm_src(imm_src), .in_tag(in_tag), .out_valid(vld32),
        .out_ready(out_ready), .imm_out(imm32), .out_tag(tag32), .out_err(err32),
        .err_seen(seen32)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(32)) dut64 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy64),
        .instr(instr), .imm_src(imm_src), .in_tag(in_tag), .out_valid(vld64),
        .out_ready(out_ready), .imm_out(imm64), .out_tag(tag64), .out_err(err64),
        .err_seen(seen64)
    );

    function automatic logic [63:0] ref_imm(input logic [31:0] ins, input logic [2:0] src,
                                            input bit is64);
        logic s;
        s = ins[31];
        case (src)
            3'd0: ref_imm = {{52{s}}, ins[31:20]};
            3'd1: ref_imm = {{52{s}}, ins[31:25], ins[11:7]};
            3'd2: ref_imm = {{51{s}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            3'd3: ref_imm = {{43{s}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            3'd4: ref_imm = {{32{s}}, ins[31:12], 12'h000};
            3'd5: ref_imm = is64 ? {58'd0, ins[25:20]} : {59'd0, ins[24:20]};
            default: ref_imm = 64'd0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", name, got, exp);
        end
    endtask

    // Check outputs against the model, clock once, then update the model
    task automatic tick();
        bit   m_push, m_pop;
        exp_t e;
        chk("in_ready32", {63'd0, rdy32}, {63'd0, q.size() != 2});
        chk("in_ready64", {63'd0, rdy64}, {63'd0, q.size() != 2});
        chk("out_valid32", {63'd0, vld32}, {63'd0, q.size() != 0});
        chk("out_valid64", {63'd0, vld64}, {63'd0, q.size() != 0});
        chk("err_seen32", {63'd0, seen32}, {63'd0, m_err_seen});
        chk("err_seen64", {63'd0, seen64}, {63'd0, m_err_seen});
        if (q.size() != 0) begin
            chk("imm32", {32'd0, imm32}, {32'd0, q[0].e32});
            chk("imm64", imm64, q[0].e64);
            chk("tag32", {32'd0, tag32}, {32'd0, q[0].tag});
            chk("tag64", {32'd0, tag64}, {32'd0, q[0].tag});
            chk("err32", {63'd0, err32}, {63'd0, q[0].err});
            chk("err64", {63'd0, err64}, {63'd0, q[0].err});
        end
        m_push = in_valid && (q.size() != 2);
        m_pop  = (q.size() != 0) && out_ready;
        e.e64  = ref_imm(instr, imm_src, 1'b1);
        e.e32  = ref_imm(instr, imm_src, 1'b0) & 64'h0000_0000_FFFF_FFFF;
        e.tag  = in_tag;
        e.err  = (imm_src == 3'd6) || (imm_src == 3'd7);
        @(posedge clk);
        if (rst) begin
            q.delete();
            m_err_seen = 1'b0;
        end else if (flush) begin
            q.delete();
        end else begin
            if (m_pop) void'(q.pop_front());
            if (m_push) begin
                q.push_back(e);
                if (e.err) m_err_seen = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [2:0] src,
                         input logic [31:0] tag);
        in_valid = v;
        instr    = ins;
        imm_src  = src;
        in_tag   = tag;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
        drive(1'b0, 32'd0, 3'd0, 32'd0);
        @(posedge clk);
        @(negedge clk);
        tick();
        rst = 1'b0;
        chk("rst_imm32", {32'd0, imm32}, 64'd0);
        chk("rst_imm64", imm64, 64'd0);
        chk("rst_tag", {32'd0, tag32}, 64'd0);
        chk("rst_err", {63'd0, err32}, 64'd0);
        tick();

        // I-format
        drive(1'b1, 32'hFFF0_0093, 3'd0, 32'h10);
        tick();
        drive(1'b0, 32'd0, 3'd0, 32'd0);
        chk("i_valid", {63'd0, vld32}, 64'd1);
        chk("i_imm32", {32'd0, imm32}, 64'h0000_0000_FFFF_FFFF);
        chk("i_imm64", imm64, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("i_err", {63'd0, err32}, 64'd0);
        tick();

        // S then J, back to back
        drive(1'b1, 32'hFE20_AE23, 3'd1, 32'h100);
        tick();
        chk("s_imm32", {32'd0, imm32}, 64'h0000_0000_FFFF_FFFC);
        chk("s_tag", {32'd0, tag32}, 64'h100);
        drive(1'b1, 32'hFFDF_F06F, 3'd3, 32'h104);
        tick();
        drive(1'b0, 32'd0, 3'd0, 32'd0);
        chk("j_imm32", {32'd0, imm32}, 64'h0000_0000_FFFF_FFFC);
        chk("j_tag", {32'd0, tag32}, 64'h104);
        tick();

        // U and SHAMT
        drive(1'b1, 32'h8000_0037, 3'd4, 32'h200);
        tick();
        chk("u_imm64", imm64, 64'hFFFF_FFFF_8000_0000);
        chk("u_imm32", {32'd0, imm32}, 64'h0000_0000_8000_0000);
        drive(1'b1, 32'h03F0_9093, 3'd5, 32'h204);
        tick();
        drive(1'b0, 32'd0, 3'd0, 32'd0);
        chk("sh_imm64", imm64, 64'h0000_0000_0000_003F);
        chk("sh_imm32", {32'd0, imm32}, 64'h0000_0000_0000_001F);
        tick();

        // Backpressure with tags 1, 2, 3
        out_ready = 1'b0;
        drive(1'b1, 32'h0010_0093, 3'd0, 32'd1);
        tick();
        drive(1'b1, 32'h0020_0093, 3'd0, 32'd2);
        tick();
        drive(1'b1, 32'h0030_0093, 3'd0, 32'd3);
        tick();
        chk("bp_in_ready", {63'd0, rdy32}, 64'd0);
        chk("bp_head", {32'd0, tag32}, 64'd1);
        tick();
        chk("bp_stable", {32'd0, tag32}, 64'd1);
        out_ready = 1'b1;
        tick();
        chk("bp_second", {32'd0, tag32}, 64'd2);
        tick();
        drive(1'b0, 32'd0, 3'd0, 32'd0);
        chk("bp_third", {32'd0, tag32}, 64'd3);
        tick();

        // Randomised traffic with occasional flush
        for (int i = 0; i < 60; i++) begin
            drive(1'($urandom_range(0, 1)), $urandom, 3'($urandom_range(0, 5)), 32'h1000 + i);
            out_ready = 1'($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            tick();
        end
        flush = 1'b0; out_ready = 1'b1;
        drive(1'b0, 32'd0, 3'd0, 32'd0);
        tick();
        tick();
        tick();

        // Illegal select; err_seen sticky through flush, cleared by rst
        drive(1'b1, 32'h1234_5678, 3'd6, 32'h300);
        tick();
        drive(1'b0, 32'd0, 3'd0, 32'd0);
        chk("ill_imm", imm64, 64'd0);
        chk("ill_err", {63'd0, err32}, 64'd1);
        chk("ill_seen", {63'd0, seen32}, 64'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("ill_seen_flush", {63'd0, seen64}, 64'd1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("ill_seen_rst", {63'd0, seen32}, 64'd0);
        tick();

        // Flush at count 2 with same-cycle input and out_ready
        out_ready = 1'b0;
        drive(1'b1, 32'h0050_0093, 3'd0, 32'h51);
        tick();
        drive(1'b1, 32'h0060_0093, 3'd0, 32'h52);
        tick();
        drive(1'b1, 32'hFFF0_0093, 3'd7, 32'h55);
        out_ready = 1'b1;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, 32'd0, 3'd0, 32'd0);
        chk("fl_valid", {63'd0, vld32}, 64'd0);
        chk("fl_ready", {63'd0, rdy32}, 64'd1);
        chk("fl_seen", {63'd0, seen32}, 64'd0);
        tick();
        drive(1'b1, 32'h0070_0093, 3'd0, 32'h66);
        tick();
        drive(1'b0, 32'd0, 3'd0, 32'd0);
        chk("fl_new_valid", {63'd0, vld64}, 64'd1);
        chk("fl_new_tag", {32'd0, tag64}, 64'h66);
        chk("fl_new_imm", imm64, 64'h7);
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Parametrised, pipelined immediate generator for the RISC-V decode stage. It takes the full 32-bit instruction word plus a 3-bit format select, and produces an XLEN-wide immediate for all RV32I/RV64I formats: I, S, B, J, U and shift-amount. Results sit in a 2-entry output buffer behind a valid/ready handshake. An optional tag (for example the PC) travels alongside each instruction. The block sits between instruction fetch/decode and the execute-stage operand mux, and supports decode-stage stall and flush.

## Interface
- XLEN, 32: immediate width; legal values are 32 and 64.
- TAG_W, 32: width of the sideband tag passed through unchanged.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous; discards all buffered and same-cycle input.
- in_valid  in  1  instr/imm_src/in_tag are valid.
- in_ready  out  1  block can accept input this cycle.
- instr  in  32  full instruction word [31:0].
- imm_src  in  3  format select (see Operation).
- in_tag  in  TAG_W  sideband data.
- out_valid  out  1  head entry is valid.
- out_ready  in  1  consumer takes the head entry this cycle.
- imm_out  out  XLEN  extended immediate of the head entry.
- out_tag  out  TAG_W  tag of the head entry.
- out_err  out  1  head entry had an illegal imm_src.
- err_seen  out  1  sticky flag: any illegal imm_src was accepted since reset.

## Operation
Format decode is combinational on the input side. Sign bit s = instr[31] in every signed format, replicated up to XLEN.
- 000 I: {s.., instr[31:20]}
- 001 S: {s.., instr[31:25], instr[11:7]}
- 010 B: {s.., instr[7], instr[30:25], instr[11:8], 0}
- 011 J: {s.., instr[19:12], instr[20], instr[30:21], 0}
- 100 U: {s.., instr[31:12], 12'b0}; for XLEN=64, bits 63:32 = s.
- 101 SHAMT: zero-extended. XLEN=32 uses instr[24:20]; XLEN=64 uses instr[25:20].
- 110, 111: illegal. Stored imm = 0, err = 1.

Buffering:
- 2-entry FIFO holding {imm, tag, err}, with an occupancy count of 0..2.
- in_ready = (count != 2). This is a registered-state function and has no combinational path from out_ready.
- Push = in_valid & in_ready. Pop = out_valid & out_ready.
- Entries leave in acceptance order.
- out_valid = (count != 0). imm_out, out_tag and out_err come from the head entry.
- err_seen is set on any push with an illegal imm_src. Only rst clears it; flush does not.

Priority, evaluated every cycle:
1. rst: count = 0, all entries cleared, err_seen = 0.
2. flush: count = 0. Same-cycle push and pop are ignored. err_seen is not updated by the dropped input.
3. Otherwise push/pop:
   - count 0: push only.
   - count 1: push+pop leaves count at 1, and the new entry becomes head next cycle.
   - count 2: pop only; no push is possible.

## Timing
- Reset values: out_valid=0, imm_out=0, out_tag=0, out_err=0, err_seen=0, in_ready=1 (the cycle after rst deasserts, and while rst is high).
- Latency: input accepted at edge N appears on out_valid/imm_out after edge N, i.e. one cycle later.
- Throughput is 1 per cycle while out_ready=1.
- With out_ready=0, two entries are absorbed, then in_ready=0 from the cycle after the second push.
- Outputs are stable while out_valid=1 and out_ready=0.
- Flush or rst mid-stream: out_valid=0 from the next cycle and in_ready=1. No partial entry survives.
- No combinational path from in_* to out_*.

## Test plan
- I-format: instr=0xFFF00093, src=000, out_ready=1 -> one cycle later out_valid=1, imm_out=0xFFFFFFFF, out_err=0.
- S and J formats: 0xFE20AE23 with src=001 -> 0xFFFFFFFC; then 0xFFDFF06F with src=011 -> 0xFFFFFFFC on the next cycle. Tags 0x100 and 0x104 appear in order.
- XLEN=64: U with 0x80000037, src=100 -> 0xFFFFFFFF80000000. SHAMT with 0x03F09093, src=101 -> 0x000000000000003F.
- Backpressure: out_ready=0 while presenting tags 1, 2, 3 -> 1 and 2 accepted, in_ready=0, 3 held. Raise out_ready -> outputs 1, 2, 3 in order with no loss or duplication.
- Illegal select: src=110 with any instr -> imm_out=0, out_err=1, err_seen=1. err_seen stays 1 through a flush and clears only on rst.
- Flush at count=2 with in_valid=1 and out_ready=1 -> next cycle out_valid=0, in_ready=1, and the input is dropped. A new push after that appears after one cycle.
